// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg -- shared types and constants for the HI/LO controller.
//   hilo_state_e   : controller FSM states (idle, multiply run, divide run)
//   hilo_wsel_e    : write-select for the HI/LO storage mux
//   DATA_W / CNT_W : datapath width and run-counter width
//   TIMEOUT_CYCLES : run length after which an operation is abandoned
//                    (only used when HILO_TIMEOUT_EN is defined)
//   cnt_sat_inc()  : saturating increment for the run counter
// -----------------------------------------------------------------------------
package hilo_pkg;

  localparam int DATA_W         = 32;
  localparam int CNT_W          = 6;
  localparam int TIMEOUT_CYCLES = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_M_RUN = 2'd1,
    ST_D_RUN = 2'd2
  } hilo_state_e;

  typedef enum logic [1:0] {
    WSEL_NONE = 2'd0,
    WSEL_MULT = 2'd1,
    WSEL_DIV  = 2'd2,
    WSEL_MOVE = 2'd3
  } hilo_wsel_e;

  // Counter sticks at all-ones so a long run never wraps back to zero,
  // where the finish flag would be treated as stale again.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// -----------------------------------------------------------------------------
// hilo_regs -- HI/LO architectural registers with write-select mux.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_sel                  : which source writes this cycle (none/mult/div/move)
//   i_mult_hi, i_mult_lo   : multiplier result halves
//   i_div_hi, i_div_lo     : divider remainder / quotient
//   i_mthi_wr, i_mtlo_wr   : individual HI/LO enables for WSEL_MOVE
//   i_wr_data              : register-file data for mthi/mtlo
//   o_hi, o_lo             : register contents, no read latency
// -----------------------------------------------------------------------------
module hilo_regs
  import hilo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  hilo_wsel_e        i_sel,
  input  logic [DATA_W-1:0] i_mult_hi,
  input  logic [DATA_W-1:0] i_mult_lo,
  input  logic [DATA_W-1:0] i_div_hi,
  input  logic [DATA_W-1:0] i_div_lo,
  input  logic              i_mthi_wr,
  input  logic              i_mtlo_wr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // NOTE: HI/LO are software-visible state that must read as zero after
  // reset, so they take the async reset like any control flop; non-blocking
  // assignments keep every flop sampling pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      case (i_sel)
        WSEL_MULT: begin
          r_hi <= i_mult_hi;
          r_lo <= i_mult_lo;
        end
        WSEL_DIV: begin
          r_hi <= i_div_hi;
          r_lo <= i_div_lo;
        end
        WSEL_MOVE: begin
          if (i_mthi_wr) r_hi <= i_wr_data;
          if (i_mtlo_wr) r_lo <= i_wr_data;
        end
        default: ;
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/hilo_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_ctrl -- sequences multiply/divide units and owns the HI/LO registers.
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_start_mult, i_start_div      : one-cycle operation requests (mult wins)
//   i_mult_done, i_mult_hi/lo      : multiplier finish flag and result
//   i_div_done, i_div_hi/lo        : divider finish flag, remainder, quotient
//   i_div_by_zero                  : divider zero-divisor flag
//   i_mthi_wr, i_mtlo_wr, i_wr_data: direct HI/LO writes (idle only)
//   o_mult_control, o_div_control  : level enables to the units
//   o_hi_out, o_lo_out             : current HI/LO
//   o_busy                         : operation in flight
//   o_done, o_div_zero_exc,
//   o_timeout_err                  : one-cycle status pulses
// Build option: define HILO_TIMEOUT_EN to abandon a run after TIMEOUT_CYCLES;
// otherwise o_timeout_err is tied low and a run waits indefinitely.
// -----------------------------------------------------------------------------
module hilo_ctrl
  import hilo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_mult,
  input  logic              i_start_div,
  input  logic              i_mult_done,
  input  logic [DATA_W-1:0] i_mult_hi,
  input  logic [DATA_W-1:0] i_mult_lo,
  input  logic              i_div_done,
  input  logic [DATA_W-1:0] i_div_hi,
  input  logic [DATA_W-1:0] i_div_lo,
  input  logic              i_div_by_zero,
  input  logic              i_mthi_wr,
  input  logic              i_mtlo_wr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_mult_control,
  output logic              o_div_control,
  output logic [DATA_W-1:0] o_hi_out,
  output logic [DATA_W-1:0] o_lo_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div_zero_exc,
  output logic              o_timeout_err
);

  hilo_state_e      r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic             r_mult_ctl, w_mult_ctl_nxt;
  logic             r_div_ctl,  w_div_ctl_nxt;
  logic             r_done,     w_done_nxt;
  logic             r_dz,       w_dz_nxt;
  hilo_wsel_e       w_sel;
  logic             w_accept;
`ifdef HILO_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic             r_timeout,  w_timeout_nxt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_mult_ctl <= 1'b0;
      r_div_ctl  <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mult_ctl <= w_mult_ctl_nxt;
      r_div_ctl  <= w_div_ctl_nxt;
      r_done     <= w_done_nxt;
      r_dz       <= w_dz_nxt;
    end
  end

`ifdef HILO_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_timeout <= 1'b0;
    else          r_timeout <= w_timeout_nxt;
  end
`endif

  // NOTE: every variable gets its default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = cnt_sat_inc(r_cnt);
    w_mult_ctl_nxt = r_mult_ctl;
    w_div_ctl_nxt  = r_div_ctl;
    w_done_nxt     = 1'b0;
    w_dz_nxt       = 1'b0;
    w_sel          = WSEL_NONE;
    w_accept       = 1'b0;
`ifdef HILO_TIMEOUT_EN
    w_timeout_nxt  = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        // A direct write is still performed alongside an accepted start;
        // the eventual result simply overwrites it.
        if (i_mthi_wr || i_mtlo_wr) w_sel = WSEL_MOVE;
        if (i_start_mult) begin
          w_state_nxt    = ST_M_RUN;
          w_mult_ctl_nxt = 1'b1;
        end else if (i_start_div) begin
          w_state_nxt   = ST_D_RUN;
          w_div_ctl_nxt = 1'b1;
        end
      end

      ST_M_RUN, ST_D_RUN: begin
        // At counter 0 the unit has not yet seen its enable, so its finish
        // flag still belongs to the previous operation.
        w_accept = (r_cnt != '0) &&
                   ((r_state == ST_M_RUN) ? i_mult_done : i_div_done);
        if (w_accept) begin
          w_state_nxt    = ST_IDLE;
          w_cnt_nxt      = '0;
          w_mult_ctl_nxt = 1'b0;
          w_div_ctl_nxt  = 1'b0;
          if (r_state == ST_M_RUN) begin
            w_sel      = WSEL_MULT;
            w_done_nxt = 1'b1;
          end else if (i_div_by_zero) begin
            w_dz_nxt = 1'b1;
          end else begin
            w_sel      = WSEL_DIV;
            w_done_nxt = 1'b1;
          end
        end
`ifdef HILO_TIMEOUT_EN
        else if (r_cnt == TIMEOUT_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_cnt_nxt      = '0;
          w_mult_ctl_nxt = 1'b0;
          w_div_ctl_nxt  = 1'b0;
          w_timeout_nxt  = 1'b1;
        end
`endif
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_cnt_nxt      = '0;
        w_mult_ctl_nxt = 1'b0;
        w_div_ctl_nxt  = 1'b0;
      end
    endcase
  end

  hilo_regs u_regs (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_sel     (w_sel),
    .i_mult_hi (i_mult_hi),
    .i_mult_lo (i_mult_lo),
    .i_div_hi  (i_div_hi),
    .i_div_lo  (i_div_lo),
    .i_mthi_wr (i_mthi_wr),
    .i_mtlo_wr (i_mtlo_wr),
    .i_wr_data (i_wr_data),
    .o_hi      (o_hi_out),
    .o_lo      (o_lo_out)
  );

  assign o_mult_control = r_mult_ctl;
  assign o_div_control  = r_div_ctl;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = r_done;
  assign o_div_zero_exc = r_dz;
`ifdef HILO_TIMEOUT_EN
  assign o_timeout_err  = r_timeout;
`else
  assign o_timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_ctrl -- self-checking bench for hilo_ctrl. The bench plays the
// multiplier/divider units itself and keeps the expected HI/LO contents in a
// small architectural model. Status outputs are compared as one vector:
//   {busy, mult_control, div_control, done, div_zero_exc, timeout_err}
// -----------------------------------------------------------------------------
module tb_hilo_ctrl;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_RUNM = 6'b110000;
  localparam logic [5:0] S_RUND = 6'b101000;
  localparam logic [5:0] S_DONE = 6'b000100;
  localparam logic [5:0] S_DZ   = 6'b000010;
  localparam logic [5:0] S_TO   = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_mult = 0, start_div = 0;
  logic        mult_done = 0, div_done = 0, div_by_zero = 0;
  logic [31:0] mult_hi = 0, mult_lo = 0, div_hi = 0, div_lo = 0;
  logic        mthi_wr = 0, mtlo_wr = 0;
  logic [31:0] wr_data = 0;
  logic        mult_control, div_control, busy, done, div_zero_exc, timeout_err;
  logic [31:0] hi_out, lo_out;

  logic [31:0] exp_hi = 0, exp_lo = 0;
  int          n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  hilo_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start_mult   (start_mult),
    .i_start_div    (start_div),
    .i_mult_done    (mult_done),
    .i_mult_hi      (mult_hi),
    .i_mult_lo      (mult_lo),
    .i_div_done     (div_done),
    .i_div_hi       (div_hi),
    .i_div_lo       (div_lo),
    .i_div_by_zero  (div_by_zero),
    .i_mthi_wr      (mthi_wr),
    .i_mtlo_wr      (mtlo_wr),
    .i_wr_data      (wr_data),
    .o_mult_control (mult_control),
    .o_div_control  (div_control),
    .o_hi_out       (hi_out),
    .o_lo_out       (lo_out),
    .o_busy         (busy),
    .o_done         (done),
    .o_div_zero_exc (div_zero_exc),
    .o_timeout_err  (timeout_err)
  );

  wire [5:0] status = {busy, mult_control, div_control, done, div_zero_exc, timeout_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_mult = 0; start_div = 0; mult_done = 0; div_done = 0; div_by_zero = 0;
    mthi_wr = 0; mtlo_wr = 0;
  endtask

  // One operation from start to result. kind: 0 mult, 1 div, 2 div by zero.
  // Returns in the cycle where the done/exception pulse is visible.
  task automatic run_op(input string name, input int kind, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input bit noise,
                        input bit mt_with_start);
    logic [31:0] r_hi_v, r_lo_v;
    logic [5:0]  run_s, end_s;
    longint      prod;
    case (kind)
      0: begin
        prod   = longint'($signed(a)) * longint'($signed(b));
        r_hi_v = prod[63:32];
        r_lo_v = prod[31:0];
      end
      1: begin
        r_hi_v = a % b;
        r_lo_v = a / b;
      end
      default: begin
        r_hi_v = $urandom;
        r_lo_v = $urandom;
      end
    endcase
    run_s = (kind == 0) ? S_RUNM : S_RUND;
    end_s = (kind == 2) ? S_DZ : S_DONE;

    if (kind == 0) start_mult = 1; else start_div = 1;
    if (mt_with_start) begin
      mthi_wr = 1;
      wr_data = $urandom;
      exp_hi  = wr_data;
    end
    tick();
    clear_inputs();
    n_total++;
    if (status !== run_s) $display("FAIL %s start_status: got %b want %b", name, status, run_s);
    else n_pass++;
    n_total++;
    if ({hi_out, lo_out} !== {exp_hi, exp_lo})
      $display("FAIL %s start_hilo: got %h_%h want %h_%h", name, hi_out, lo_out, exp_hi, exp_lo);
    else n_pass++;

    for (int i = 0; i < lat; i++) begin
      if (noise) begin
        start_mult = 1'($urandom);
        start_div  = 1'($urandom);
        mthi_wr    = 1'($urandom);
        mtlo_wr    = 1'($urandom);
        wr_data    = $urandom;
        if (kind == 0) div_done = 1'($urandom); else mult_done = 1'($urandom);
      end
      tick();
      n_total++;
      if (status !== run_s || {hi_out, lo_out} !== {exp_hi, exp_lo})
        $display("FAIL %s run_cycle%0d: got %b %h_%h want %b %h_%h", name, i,
                 status, hi_out, lo_out, run_s, exp_hi, exp_lo);
      else n_pass++;
    end

    clear_inputs();
    if (kind == 0) begin
      mult_done = 1; mult_hi = r_hi_v; mult_lo = r_lo_v;
    end else begin
      div_done = 1; div_by_zero = (kind == 2); div_hi = r_hi_v; div_lo = r_lo_v;
    end
    tick();
    clear_inputs();
    if (kind != 2) begin
      exp_hi = r_hi_v;
      exp_lo = r_lo_v;
    end
    n_total++;
    if (status !== end_s) $display("FAIL %s end_status: got %b want %b", name, status, end_s);
    else n_pass++;
    n_total++;
    if ({hi_out, lo_out} !== {exp_hi, exp_lo})
      $display("FAIL %s end_hilo: got %h_%h want %h_%h", name, hi_out, lo_out, exp_hi, exp_lo);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    tick(); tick();
    n_total++;
    if (status !== S_IDLE || {hi_out, lo_out} !== 64'd0)
      $display("FAIL reset_hold: got %b %h_%h want %b 0", status, hi_out, lo_out, S_IDLE);
    else n_pass++;
    rst_n = 1;
    exp_hi = 0; exp_lo = 0;
    tick();
    n_total++;
    if (status !== S_IDLE || {hi_out, lo_out} !== 64'd0)
      $display("FAIL reset_release: got %b %h_%h want %b 0", status, hi_out, lo_out, S_IDLE);
    else n_pass++;
  endtask

  // First operation after reset, with the multiplier's finish flag still high.
  task automatic test_stale();
    mult_done = 1; mult_hi = 32'hAAAA_AAAA; mult_lo = 32'h5555_5555;
    start_mult = 1;
    tick();
    start_mult = 0;
    n_total++;
    if (status !== S_RUNM) $display("FAIL stale_enter: got %b want %b", status, S_RUNM);
    else n_pass++;
    tick();
    mult_done = 0;
    n_total++;
    if (status !== S_RUNM) $display("FAIL stale_ignored_status: got %b want %b", status, S_RUNM);
    else n_pass++;
    n_total++;
    if ({hi_out, lo_out} !== {exp_hi, exp_lo})
      $display("FAIL stale_ignored_hilo: got %h_%h want %h_%h", hi_out, lo_out, exp_hi, exp_lo);
    else n_pass++;
    tick();
    mult_done = 1; mult_hi = 32'h1234_5678; mult_lo = 32'h9ABC_DEF0;
    tick();
    mult_done = 0;
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
    n_total++;
    if (status !== S_DONE || {hi_out, lo_out} !== {exp_hi, exp_lo})
      $display("FAIL stale_fresh_done: got %b %h_%h want %b %h_%h", status, hi_out, lo_out,
               S_DONE, exp_hi, exp_lo);
    else n_pass++;
    tick();
  endtask

  task automatic test_mult();
    run_op("mult_7x-3", 0, 32'd7, -32'sd3, 3, 0, 0);
    n_total++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB)
      $display("FAIL mult_7x-3_value: got %h_%h want ffffffff_ffffffeb", hi_out, lo_out);
    else n_pass++;
    tick();
    n_total++;
    if (status !== S_IDLE) $display("FAIL mult_after: got %b want %b", status, S_IDLE);
    else n_pass++;
  endtask

  task automatic test_div();
    run_op("div_100/7", 1, 32'd100, 32'd7, 5, 0, 0);
    n_total++;
    if (hi_out !== 32'd2 || lo_out !== 32'd14)
      $display("FAIL div_100/7_value: got %0d/%0d want 2/14", hi_out, lo_out);
    else n_pass++;
    tick();
    run_op("div_5/0", 2, 32'd5, 32'd0, 4, 0, 0);
    n_total++;
    if (hi_out !== 32'd2 || lo_out !== 32'd14)
      $display("FAIL div_by_zero_keep: got %0d/%0d want 2/14", hi_out, lo_out);
    else n_pass++;
    tick();
    n_total++;
    if (status !== S_IDLE) $display("FAIL div_by_zero_after: got %b want %b", status, S_IDLE);
    else n_pass++;
  endtask

  task automatic test_priority();
    start_mult = 1; start_div = 1;
    tick();
    clear_inputs();
    n_total++;
    if (status !== S_RUNM) $display("FAIL prio_both_start: got %b want %b", status, S_RUNM);
    else n_pass++;
    start_div = 1;
    tick();
    start_div = 0;
    n_total++;
    if (status !== S_RUNM) $display("FAIL prio_div_while_busy: got %b want %b", status, S_RUNM);
    else n_pass++;
    mthi_wr = 1; wr_data = 32'hDEAD;
    tick();
    mthi_wr = 0;
    n_total++;
    if (hi_out !== exp_hi) $display("FAIL prio_mthi_while_busy: got %h want %h", hi_out, exp_hi);
    else n_pass++;
    mult_done = 1; mult_hi = 32'h0000_0001; mult_lo = 32'h0000_0002;
    tick();
    mult_done = 0;
    exp_hi = 32'h1; exp_lo = 32'h2;
    n_total++;
    if (status !== S_DONE || {hi_out, lo_out} !== {exp_hi, exp_lo})
      $display("FAIL prio_finish: got %b %h_%h want %b %h_%h", status, hi_out, lo_out,
               S_DONE, exp_hi, exp_lo);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 0, 32'd1000, 32'd1000, 2, 0, 0);
    // Done pulse cycle: enable already low, new start accepted right here.
    n_total++;
    if (mult_control !== 1'b0 || done !== 1'b1)
      $display("FAIL b2b_gap: got ctl=%b done=%b want ctl=0 done=1", mult_control, done);
    else n_pass++;
    run_op("b2b_second", 1, 32'd12345, 32'd100, 2, 0, 1);
    run_op("b2b_third", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1);
    tick();
  endtask

  task automatic test_random();
    int          kind;
    logic [31:0] a, b;
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      b = $urandom;
      if (kind == 1 && b == 0) b = 1;
      run_op($sformatf("rand%0d", it), kind, a, b, $urandom_range(1, 34), 1, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 2; k++) begin
          mthi_wr = 1'($urandom);
          mtlo_wr = 1'($urandom);
          wr_data = $urandom;
          if (mthi_wr) exp_hi = wr_data;
          if (mtlo_wr) exp_lo = wr_data;
          tick();
          clear_inputs();
          n_total++;
          if (status !== S_IDLE || {hi_out, lo_out} !== {exp_hi, exp_lo})
            $display("FAIL rand%0d_move%0d: got %b %h_%h want %b %h_%h", it, k, status,
                     hi_out, lo_out, S_IDLE, exp_hi, exp_lo);
          else n_pass++;
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mthi_wr = 1; mtlo_wr = 1; wr_data = 32'hCAFE_F00D;
    tick();
    clear_inputs();
    start_mult = 1;
    tick();
    start_mult = 0;
    repeat (10) tick();
    n_total++;
    if (status !== S_RUNM || hi_out !== 32'hCAFE_F00D)
      $display("FAIL rstmid_pre: got %b %h want %b cafef00d", status, hi_out, S_RUNM);
    else n_pass++;
    rst_n = 0;
    #1;
    exp_hi = 0; exp_lo = 0;
    n_total++;
    if (status !== S_IDLE || {hi_out, lo_out} !== 64'd0)
      $display("FAIL rstmid_async: got %b %h_%h want %b 0", status, hi_out, lo_out, S_IDLE);
    else n_pass++;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_timeout();
    start_mult = 1;
    tick();
    start_mult = 0;
`ifdef HILO_TIMEOUT_EN
    repeat (39) tick();
    n_total++;
    if (status !== S_RUNM) $display("FAIL timeout_before: got %b want %b", status, S_RUNM);
    else n_pass++;
    tick();
    n_total++;
    if (status !== S_TO || {hi_out, lo_out} !== {exp_hi, exp_lo})
      $display("FAIL timeout_fire: got %b %h_%h want %b %h_%h", status, hi_out, lo_out,
               S_TO, exp_hi, exp_lo);
    else n_pass++;
    tick();
    n_total++;
    if (status !== S_IDLE) $display("FAIL timeout_after: got %b want %b", status, S_IDLE);
    else n_pass++;
`else
    repeat (45) tick();
    n_total++;
    if (status !== S_RUNM) $display("FAIL notimeout_wait: got %b want %b", status, S_RUNM);
    else n_pass++;
    mult_done = 1; mult_hi = 32'h0BAD_0BAD; mult_lo = 32'h600D_600D;
    tick();
    mult_done = 0;
    exp_hi = 32'h0BAD_0BAD; exp_lo = 32'h600D_600D;
    n_total++;
    if (status !== S_DONE || {hi_out, lo_out} !== {exp_hi, exp_lo})
      $display("FAIL notimeout_finish: got %b %h_%h want %b %h_%h", status, hi_out, lo_out,
               S_DONE, exp_hi, exp_lo);
    else n_pass++;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_stale();
    test_mult();
    test_div();
    test_priority();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 clock  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-003 start_mult  in  1  one-cycle request to run a multiply.
REQ-004 start_div  in  1  one-cycle request to run a divide.
REQ-005 mult_done, mult_hi[31:0], mult_lo[31:0]  in  1/32/32  multiplier finish flag and result halves.
REQ-006 div_done, div_hi[31:0], div_lo[31:0], div_by_zero  in  1/32/32/1  divider finish flag, remainder, quotient, zero-divisor flag.
REQ-007 mthi_wr, mtlo_wr, wr_data[31:0]  in  1/1/32  direct HI/LO writes from the register file.
REQ-008 mult_control, div_control  out  1  level enables to the multiplier and divider units.
REQ-009 hi_out, lo_out  out  32  current HI/LO contents, read by mfhi/mflo.
REQ-010 busy  out  1  high while an operation is in flight; the control unit stalls on it.
REQ-011 done, div_zero_exc, timeout_err  out  1  one-cycle status pulses.

Function
REQ-012 States: IDLE, M_RUN, D_RUN; busy SHALL equal (state != IDLE).
REQ-013 IDLE, start_mult=1 -> M_RUN, mult_control=1 from the next edge; start_mult and start_div both high -> multiply wins, divide dropped.
REQ-014 IDLE, start_div=1 (start_mult=0) -> D_RUN, div_control=1 from the next edge.
REQ-015 6-bit run counter cleared on entry to M_RUN/D_RUN, incremented every cycle in a run state, saturating at 63.
REQ-016 mult_done/div_done SHALL be ignored while counter==0, because the unit's finish flag is stale from the previous operation until the unit sees its enable.
REQ-017 M_RUN, counter>=1, mult_done=1 -> on that edge HI<=mult_hi, LO<=mult_lo, mult_control<=0, state<=IDLE, done<=1 for exactly one cycle.
REQ-018 D_RUN, counter>=1, div_done=1, div_by_zero=0 -> HI<=div_hi, LO<=div_lo, div_control<=0, IDLE, done pulse.
REQ-019 D_RUN, counter>=1, div_done=1, div_by_zero=1 -> HI/LO unchanged, div_control<=0, IDLE, div_zero_exc pulse, no done pulse.
REQ-020 The enable SHALL be low for at least one cycle between consecutive operations, so the unit re-initialises; a start in the same cycle as a done pulse SHALL be accepted.
REQ-021 start_mult/start_div while busy SHALL be ignored, with no queueing.
REQ-022 mthi_wr/mtlo_wr in IDLE SHALL write wr_data on the next edge; while busy they SHALL be ignored. Both may be high in the same cycle.
REQ-023 mthi_wr together with an accepted start in IDLE: the write is performed; the later result overwrites it.
REQ-024 hi_out/lo_out SHALL be driven directly from the registers, with zero read latency.

Reset
REQ-025 reset low: state=IDLE, HI=LO=0, counter=0, and mult_control, div_control, busy, done, div_zero_exc, timeout_err all 0, asynchronously, including mid-operation.
REQ-026 First operation after reset release SHALL obey REQ-016.

Configuration
REQ-027 Macro HILO_TIMEOUT_EN defined: in a run state with counter==TIMEOUT_CYCLES-1 and no accepted done -> enable<=0, IDLE, timeout_err pulse, HI/LO unchanged.
REQ-028 TIMEOUT_CYCLES default is 40; the multiplier needs 34.
REQ-029 HILO_TIMEOUT_EN undefined: timeout_err is tied 0 and a run state waits indefinitely.

Structure
REQ-030 Shared package hilo_pkg: state enum, TIMEOUT_CYCLES, DATA_W=32, CNT_W=6.
REQ-031 Sub-module hilo_regs: HI/LO storage with write-select mux (mult result, div result, mthi/mtlo).

Verification
REQ-032 mult 7 x -3: start_mult -> mult_control high; result HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; single done pulse; busy low after.
REQ-033 div 100/7: start_div -> HI=2, LO=14, done pulse; then div 5/0 with div_by_zero -> HI/LO keep 2/14, div_zero_exc pulse, no done.
REQ-034 Stale flag: mult_done held high from the previous op at the start edge -> not accepted at counter==0; HI/LO not updated until the fresh done.
REQ-035 start_mult+start_div in the same cycle -> only mult_control rises; start_div during M_RUN ignored; mthi_wr 32'hDEAD during M_RUN ignored.
REQ-036 reset low at counter==10 in M_RUN -> HI/LO=0 and mult_control=0 immediately; with HILO_TIMEOUT_EN and done never asserted -> timeout_err at counter 39.
